// File: rtl/matrix_scan_controller.sv
// Row-scan controller for the 5x7 LED matrix: multiplexes seven row presets onto the
// shared column bus, drives active-low row enables, and latches HH on frame boundaries.
// Optional: define SCAN_BLANK_EN to blank col for the first cycle of every row slot.
module matrix_scan_controller #(
  parameter int unsigned DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  HH,
  input  logic [34:0] cl_all,
  output logic [1:0]  hh_q,
  output logic [4:0]  col,
  output logic [6:0]  ln,
  output logic        frame_done
);

  localparam int unsigned CW      = 16;
  localparam int unsigned RW      = 3;
  localparam int unsigned NCOL    = 5;
  localparam int unsigned NROW    = 7;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(NROW - 1);

  logic [CW-1:0]   cnt, cnt_nx;
  logic [RW-1:0]   row, row_nx;
  logic [1:0]      hh_nx;
  logic [NROW-1:0] ln_nx;
  logic [NCOL-1:0] col_nx;
  logic            tick, wrap;

  // Next-state and next-output computation; outputs track row_nx so ln/col/row agree.
  always_comb begin
    cnt_nx = cnt;
    row_nx = row;
    hh_nx  = hh_q;
    ln_nx  = 7'h7F;
    col_nx = '0;
    tick   = en && (cnt == CNT_MAX);
    wrap   = tick && (row == LAST_ROW);

    if (tick)    cnt_nx = '0;
    else if (en) cnt_nx = cnt + CW'(1);

    if (row > LAST_ROW) row_nx = '0;
    else if (wrap)      row_nx = '0;
    else if (tick)      row_nx = row + RW'(1);

    // Idle cycles track HH freely; while scanning only the frame boundary captures it.
    if (!en || wrap) hh_nx = HH;

    if (en) begin
      ln_nx  = ~(NROW'(1) << row_nx);
      col_nx = cl_all[int'(row_nx)*NCOL +: NCOL];
`ifdef SCAN_BLANK_EN
      if (tick) col_nx = '0;
`else
      col_nx = col_nx;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      row        <= '0;
      hh_q       <= 2'b00;
      ln         <= 7'h7F;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nx;
      row        <= row_nx;
      hh_q       <= hh_nx;
      ln         <= ln_nx;
      col        <= col_nx;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Self-checking bench for matrix_scan_controller: frame-position reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_matrix_scan_controller;

  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = 7 * DIV;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  HH;
  logic [34:0] cl_all;
  logic [1:0]  hh_q;
  logic [4:0]  col;
  logic [6:0]  ln;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model: absolute position within the frame plus latched pattern.
  int          m_pos;
  logic [1:0]  m_hh;
  logic [6:0]  m_ln;
  logic [4:0]  m_col;
  logic        m_fd;

  matrix_scan_controller #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .HH(HH), .cl_all(cl_all),
    .hh_q(hh_q), .col(col), .ln(ln), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Row preset data: pattern h, row k -> {h, k+1}.
  function automatic logic [4:0] pat(input int h, input int k);
    return 5'((h << 3) | (k + 1));
  endfunction

  function automatic logic [34:0] presets(input logic [1:0] h);
    logic [34:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) v[k*5 +: 5] = pat(int'(h), k);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int row;
    logic [34:0] clv;
    clv = cl_all;
    if (rst) begin
      m_pos = 0; m_hh = 2'b00; m_ln = 7'h7F; m_col = '0; m_fd = 1'b0;
    end else begin
      m_fd = en && (m_pos == FRAME - 1);
      if (en) m_pos = (m_pos + 1) % FRAME;
      if (!en || m_fd) m_hh = HH;
      row = m_pos / DIV;
      if (en) begin
        m_ln  = ~(7'(1) << row);
        m_col = clv[row*5 +: 5];
`ifdef SCAN_BLANK_EN
        if (m_pos % DIV == 0) m_col = '0;
`endif
      end else begin
        m_ln  = 7'h7F;
        m_col = '0;
      end
    end
  endtask

  // One clock: present inputs, advance model on the edge, compare just after it.
  task automatic step();
    cl_all = presets(m_hh);
    @(posedge clk);
    model_update();
    #1;
    chk("ln", int'(ln), int'(m_ln));
    chk("col", int'(col), int'(m_col));
    chk("hh_q", int'(hh_q), int'(m_hh));
    chk("frame_done", int'(frame_done), int'(m_fd));
    chk("ln_onehot", int'($countones(~ln) <= 1), 1);
  endtask

  logic [6:0] scan_ln [7];

  initial begin
    int e;
    int fd_edge [2];
    int fd_n;
    scan_ln[0] = 7'h7E; scan_ln[1] = 7'h7D; scan_ln[2] = 7'h7B; scan_ln[3] = 7'h77;
    scan_ln[4] = 7'h6F; scan_ln[5] = 7'h5F; scan_ln[6] = 7'h3F;
    m_pos = 0; m_hh = 2'b00; m_ln = 7'h7F; m_col = '0; m_fd = 1'b0;
    rst = 1'b1; en = 1'b1; HH = 2'b11; cl_all = '0;

    // Reset held 3 cycles with en=1 and HH=3.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ln", int'(ln), 'h7F);
      chk("rst_col", int'(col), 0);
      chk("rst_hh", int'(hh_q), 0);
      chk("rst_fd", int'(frame_done), 0);
    end

    // Frame 1: HH=0, switched to 2 during row 3; frame 2 checks scan order.
    rst = 1'b0; HH = 2'b00;
    fd_n = 0;
    for (e = 1; e <= 2 * FRAME + 1; e++) begin
      if (e == 13) HH = 2'b10;
      step();
      if (e == 1) begin
        chk("first_ln", int'(ln), 'h7E);
        chk("first_col", int'(col), 1);
      end
      if (e < FRAME) chk("hh_hold", int'(hh_q), 0);
      if (e == FRAME) begin
        chk("wrap_fd", int'(frame_done), 1);
        chk("wrap_ln", int'(ln), 'h7E);
        chk("wrap_hh", int'(hh_q), 2);
      end
      if (e == FRAME + 1) begin
        chk("fd_pulse", int'(frame_done), 0);
        chk("newpat_col", int'(col), 'h11);
      end
      if (e > FRAME && e <= 2 * FRAME && ((e - FRAME - 1) % DIV == 0)) begin
        chk("scan_ln", int'(ln), int'(scan_ln[(e - FRAME - 1) / DIV]));
        chk("scan_col", int'(col), int'(pat(2, (e - FRAME - 1) / DIV)));
      end
      if (frame_done && fd_n < 2) begin fd_edge[fd_n] = e; fd_n++; end
    end
    chk("fd_count", fd_n, 2);
    if (fd_n == 2) chk("fd_period", fd_edge[1] - fd_edge[0], FRAME);

    // Advance to row 2, cnt=1 (position 9), then pause 5 cycles.
    while (m_pos != 2 * DIV + 1) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause_ln", int'(ln), 'h7F);
      chk("pause_col", int'(col), 0);
    end
    en = 1'b1;
    step(); chk("resume_ln0", int'(ln), 'h7B);
    step(); chk("resume_ln1", int'(ln), 'h7B);
    step(); chk("resume_ln2", int'(ln), 'h77);

    // Reset pulse during row 5; no frame_done afterwards before a full frame.
    while (m_pos / DIV != 5) step();
    rst = 1'b1;
    step();
    chk("mid_rst_ln", int'(ln), 'h7F);
    chk("mid_rst_col", int'(col), 0);
    chk("mid_rst_fd", int'(frame_done), 0);
    rst = 1'b0;
    step();
    chk("restart_ln", int'(ln), 'h7E);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("no_fd", int'(frame_done), 0);
    end

    // Randomized phase.
    for (int i = 0; i < 2000; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      HH  = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 249) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
